// File: rtl/cgu_freq_seq.sv
// Clock-frequency change sequencer: safe dividers -> clktop source switch -> target dividers.
// Latency 3+2*SETTLE same-source, longer for a switch (WAITEN >= 2 cycles, +2 with CGU_FREQ_SEQ_SYNC_EN).
// No backpressure: req is taken only while idle and not busy, otherwise dropped.
module cgu_freq_seq #(
  parameter int OCNT   = 6,
  parameter int FDW    = 8,
  parameter int SETTLE = 16,
  parameter int TOCNT  = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req,
  input  logic                 tgtsel,
  input  logic [OCNT*FDW-1:0]  tgtfd,
  input  logic [OCNT*FDW-1:0]  safefd,
  input  logic [1:0]           clktopselen,
  output logic [OCNT*FDW-1:0]  fd,
  output logic                 fdload,
  output logic                 clktopsel,
  output logic                 clktopselupdate,
  output logic                 cursel,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CMAX = (SETTLE > TOCNT) ? SETTLE : TOCNT;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TO_END     = CW'(TOCNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LDSAFE, S_SETTLE1, S_SWITCH, S_WAITEN, S_LDTGT, S_SETTLE2, S_DONE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic                 tsel_q;
  logic [OCNT*FDW-1:0]  tfd_q;
  logic                 seen;
  logic [1:0]           en_use;
  logic                 matched;

`ifdef CGU_FREQ_SEQ_SYNC_EN
  logic [1:0] en_s1;
  logic [1:0] en_s2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_s1 <= '0;
      en_s2 <= '0;
    end else begin
      en_s1 <= clktopselen;
      en_s2 <= en_s1;
    end
  end

  assign en_use = en_s2;
`else
  assign en_use = clktopselen;
`endif

  // bit0 is the source-0 enable, bit1 the source-1 enable
  assign matched = (en_use == {tsel_q, ~tsel_q});
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_IDLE;
      cnt             <= '0;
      tsel_q          <= 1'b0;
      tfd_q           <= '0;
      seen            <= 1'b0;
      fd              <= '0;
      fdload          <= 1'b0;
      clktopsel       <= 1'b0;
      clktopselupdate <= 1'b0;
      cursel          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      fdload          <= 1'b0;
      clktopselupdate <= 1'b0;
      done            <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy still high here means we just left DONE or a timeout
          busy <= 1'b0;
          if (req && !busy) begin
            tsel_q <= tgtsel;
            tfd_q  <= tgtfd;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_LDSAFE;
          end
        end
        S_LDSAFE: begin
          fd     <= safefd;
          fdload <= 1'b1;
          cnt    <= '0;
          state  <= S_SETTLE1;
        end
        S_SETTLE1: begin
          cnt <= cnt_inc;
          if (cnt == SETTLE_END) begin
            state <= (tsel_q == cursel) ? S_LDTGT : S_SWITCH;
          end
        end
        S_SWITCH: begin
          clktopsel       <= tsel_q;
          clktopselupdate <= 1'b1;
          cnt             <= '0;
          seen            <= 1'b0;
          state           <= S_WAITEN;
        end
        S_WAITEN: begin
          cnt  <= cnt_inc;
          seen <= matched;
          // a mismatch restarts qualification; the timeout keeps running
          if (matched && seen) begin
            cursel <= tsel_q;
            state  <= S_LDTGT;
          end else if (cnt == TO_END) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_LDTGT: begin
          fd     <= tfd_q;
          fdload <= 1'b1;
          cnt    <= '0;
          state  <= S_SETTLE2;
        end
        S_SETTLE2: begin
          cnt <= cnt_inc;
          if (cnt == SETTLE_END) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgu_freq_seq.sv
// Directed bench for cgu_freq_seq: same-source, switch, timeout, glitch, busy-req and mid-sequence reset.
module tb_cgu_freq_seq;

  localparam int OCNT   = 6;
  localparam int FDW    = 8;
  localparam int FW     = OCNT * FDW;
  localparam int SETTLE = 16;
  localparam int TOCNT  = 64;
`ifdef CGU_FREQ_SEQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam logic [FW-1:0] SAFE = {OCNT{8'h7F}};
  localparam int U = 2 + SETTLE;

  logic          clk = 1'b0;
  logic          resetn, req, tgtsel;
  logic [FW-1:0] tgtfd, safefd;
  logic [1:0]    clktopselen;
  logic [FW-1:0] fd;
  logic          fdload, clktopsel, clktopselupdate, cursel, busy, done, err;

  cgu_freq_seq #(.OCNT(OCNT), .FDW(FDW), .SETTLE(SETTLE), .TOCNT(TOCNT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .tgtsel(tgtsel), .tgtfd(tgtfd),
    .safefd(safefd), .clktopselen(clktopselen), .fd(fd), .fdload(fdload),
    .clktopsel(clktopsel), .clktopselupdate(clktopselupdate), .cursel(cursel),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fl, n_upd, n_done, fl_cyc0, fl_cyc1, upd_cyc, cur_cyc, done_cyc, err_cyc, busy0_cyc;
  logic [FW-1:0] fl_fd0, fl_fd1;
  logic          upd_sel, err0, busy_k0;
  logic [1:0]    pat[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one req, then samples cycles 0..ncyc after the accepting edge.
  task automatic run_req(input logic sel, input logic [FW-1:0] tfd, input int ncyc, input int req2_at);
    logic cur0;
    logic upd_seen;
    int   pi;
    n_fl = 0; n_upd = 0; n_done = 0; fl_cyc0 = -1; fl_cyc1 = -1; upd_cyc = -1;
    cur_cyc = -1; done_cyc = -1; err_cyc = -1; busy0_cyc = -1;
    fl_fd0 = '0; fl_fd1 = '0; upd_sel = 1'b0; upd_seen = 1'b0; pi = 0;
    cur0 = cursel;
    tgtsel = sel; tgtfd = tfd; req = 1'b1;
    step();
    req = 1'b0;
    err0 = err; busy_k0 = busy;
    for (int k = 0; k <= ncyc; k++) begin
      if (fdload) begin
        if (n_fl == 0) begin fl_cyc0 = k; fl_fd0 = fd; end
        if (n_fl == 1) begin fl_cyc1 = k; fl_fd1 = fd; end
        n_fl++;
      end
      if (clktopselupdate) begin
        if (n_upd == 0) begin upd_cyc = k; upd_sel = clktopsel; end
        n_upd++;
        upd_seen = 1'b1;
      end
      if (done) begin
        if (n_done == 0) done_cyc = k;
        n_done++;
      end
      if (err && err_cyc < 0) err_cyc = k;
      if (cursel != cur0 && cur_cyc < 0) cur_cyc = k;
      if (!busy && busy0_cyc < 0) busy0_cyc = k;
      if (upd_seen && pat.size() > 0) begin
        clktopselen = pat[(pi < pat.size()) ? pi : pat.size() - 1];
        pi++;
      end
      if (k == req2_at) begin
        req = 1'b1;
        tgtsel = ~sel;
      end else begin
        req = 1'b0;
      end
      if (k < ncyc) step();
    end
    req = 1'b0;
  endtask

  int d_cnt, b_cnt;

  initial begin
    resetn = 1'b0; req = 1'b0; tgtsel = 1'b0; tgtfd = '0; safefd = SAFE;
    clktopselen = 2'b01;
    step(); step(); step();
    check("rst_fd", fd, 0);
    check("rst_fdload", fdload, 0);
    check("rst_clktopsel", clktopsel, 0);
    check("rst_upd", clktopselupdate, 0);
    check("rst_cursel", cursel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;
    step();

    // same source
    pat.delete();
    run_req(1'b0, {OCNT{8'h03}}, 40, -1);
    check("t1_busy_k0", busy_k0, 1);
    check("t1_n_fdload", n_fl, 2);
    check("t1_fl0_cyc", fl_cyc0, 1);
    check("t1_fl0_fd", fl_fd0, SAFE);
    check("t1_fl1_cyc", fl_cyc1, 2 + SETTLE);
    check("t1_fl1_fd", fl_fd1, {OCNT{8'h03}});
    check("t1_n_upd", n_upd, 0);
    check("t1_n_done", n_done, 1);
    check("t1_done_cyc", done_cyc, 3 + 2 * SETTLE);
    check("t1_busy_fall", busy0_cyc, 4 + 2 * SETTLE);

    // switch to source 1 with dead time
    pat.delete();
    for (int i = 0; i < 5; i++) pat.push_back(2'b00);
    pat.push_back(2'b10);
    clktopselen = 2'b01;
    run_req(1'b1, {OCNT{8'h05}}, 60, -1);
    check("t2_n_upd", n_upd, 1);
    check("t2_upd_cyc", upd_cyc, U);
    check("t2_upd_sel", upd_sel, 1);
    check("t2_cur_cyc", cur_cyc, U + 7 + SL);
    check("t2_fl1_cyc", fl_cyc1, U + 8 + SL);
    check("t2_fl1_fd", fl_fd1, {OCNT{8'h05}});
    check("t2_done_cyc", done_cyc, U + 9 + SL + SETTLE);
    check("t2_n_done", n_done, 1);
    check("t2_cursel", cursel, 1);

    // timeout from a fresh reset
    resetn = 1'b0; clktopselen = 2'b01;
    step(); step();
    resetn = 1'b1;
    step();
    pat.delete();
    pat.push_back(2'b00);
    run_req(1'b1, {OCNT{8'h09}}, U + TOCNT + 4, -1);
    check("t3_err_cyc", err_cyc, U + TOCNT);
    check("t3_busy_fall", busy0_cyc, U + TOCNT + 1);
    check("t3_n_done", n_done, 0);
    check("t3_n_fdload", n_fl, 1);
    check("t3_fd", fd, SAFE);
    check("t3_cursel", cursel, 0);
    check("t3_clktopsel", clktopsel, 1);
    check("t3_err_sticky", err, 1);

    pat.delete();
    run_req(1'b0, {OCNT{8'h02}}, 40, -1);
    check("t3b_err_clr", err0, 0);
    check("t3b_done_cyc", done_cyc, 3 + 2 * SETTLE);
    check("t3b_fd", fd, {OCNT{8'h02}});

    // glitch on the enable pair
    pat.delete();
    pat.push_back(2'b10);
    for (int i = 0; i < 3; i++) pat.push_back(2'b00);
    pat.push_back(2'b10);
    clktopselen = 2'b01;
    run_req(1'b1, {OCNT{8'h11}}, 60, -1);
    check("t4_cur_cyc", cur_cyc, U + 6 + SL);
    check("t4_fl1_cyc", fl_cyc1, U + 7 + SL);
    check("t4_done_cyc", done_cyc, U + 8 + SL + SETTLE);
    check("t4_n_done", n_done, 1);

    // second req while busy is dropped
    pat.delete();
    run_req(1'b1, {OCNT{8'h21}}, 70, 5);
    check("t5_n_done", n_done, 1);
    check("t5_n_upd", n_upd, 0);
    check("t5_done_cyc", done_cyc, 3 + 2 * SETTLE);
    check("t5_fd", fd, {OCNT{8'h21}});

    // reset during SETTLE2, with req held to show reset priority
    pat.delete();
    run_req(1'b1, {OCNT{8'h33}}, 25, -1);
    resetn = 1'b0; req = 1'b1;
    step();
    check("t6_fd", fd, 0);
    check("t6_fdload", fdload, 0);
    check("t6_clktopsel", clktopsel, 0);
    check("t6_upd", clktopselupdate, 0);
    check("t6_cursel", cursel, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_err", err, 0);
    resetn = 1'b1; req = 1'b0;
    d_cnt = 0; b_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) d_cnt++;
      if (busy) b_cnt++;
    end
    check("t6_no_done", d_cnt, 0);
    check("t6_no_busy", b_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
